// File: rtl/fetch_unit.sv
// Instruction-fetch stage. It owns the fetch PC and issues in-order word reads
// to instruction memory. Each returned word is paired with the PC it was fetched
// from and held in a small circular buffer, which decode drains through a
// valid/ready handshake. A redirect restarts fetch at a new target. Responses
// still in flight for wrong-path requests are counted in a drop counter and
// discarded as they arrive.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]      fpc_q, fpc_d;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [31:0]      word_q [DEPTH];
  logic [31:0]      word_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]    alloc_q, alloc_d;
  logic [AW-1:0]    fill_q, fill_d;
  logic [AW-1:0]    head_q, head_d;
  logic [CW-1:0]    count_q, count_d;   // allocated entries
  logic [CW-1:0]    pend_q, pend_d;     // allocated entries still awaiting data
  logic [CW-1:0]    drop_q, drop_d;     // wrong-path responses still to discard

  logic accept_s;
  logic consume_s;
  logic resp_drop_s;
  logic resp_fill_s;

  // Slots are shared by outstanding requests and buffered words, so the
  // discard backlog also holds off new requests.
  assign imem_req   = !rst && !redirect && (({1'b0, count_q} + {1'b0, drop_q}) < DEPTH_W);
  assign imem_addr  = fpc_q;
  assign inst_valid = !rst && (count_q != CNT_ZERO) && filled_q[head_q];
  assign inst       = word_q[head_q];
  assign inst_pc    = pc_q[head_q];

  // Handshake qualifiers for the current cycle.
  always_comb begin
    accept_s    = imem_req && imem_gnt;
    consume_s   = inst_valid && inst_ready;
    resp_drop_s = imem_rvalid && (drop_q != CNT_ZERO);
    resp_fill_s = imem_rvalid && (drop_q == CNT_ZERO) && (pend_q != CNT_ZERO);
  end

  // Next-state logic: redirect flushes everything, otherwise consume/fill/allocate.
  always_comb begin
    fpc_d    = fpc_q;
    pc_d     = pc_q;
    word_d   = word_q;
    filled_d = filled_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    head_d   = head_q;
    count_d  = count_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    if (redirect) begin
      // Clearing the low bits with a mask keeps every target bit in the logic.
      fpc_d    = redirect_pc & 32'hFFFF_FFFC;
      filled_d = {DEPTH{1'b0}};
      alloc_d  = PTR_ZERO;
      fill_d   = PTR_ZERO;
      head_d   = PTR_ZERO;
      count_d  = CNT_ZERO;
      pend_d   = CNT_ZERO;
      // Every request still in flight must be discarded. A response that
      // arrives this very cycle is already one of them and is gone now.
      drop_d   = drop_q + pend_q
               - CW'(imem_rvalid && ((drop_q != CNT_ZERO) || (pend_q != CNT_ZERO)));
    end else begin
      // The consumed head is never the entry being filled or allocated this cycle.
      if (consume_s) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      if (resp_drop_s) begin
        drop_d = drop_q - CW'(1);
      end else if (resp_fill_s) begin
        word_d[fill_q]   = imem_rdata;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PTR_ONE;
      end else begin
        drop_d = drop_q;
      end
      if (accept_s) begin
        pc_d[alloc_q]     = fpc_q;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + PTR_ONE;
        fpc_d             = fpc_q + 32'd4;
      end else begin
        fpc_d = fpc_q;
      end
      count_d = count_q + CW'(accept_s) - CW'(consume_s);
      pend_d  = pend_q + CW'(accept_s) - CW'(resp_fill_s);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q    <= RESET_PC;
      filled_q <= {DEPTH{1'b0}};
      alloc_q  <= PTR_ZERO;
      fill_q   <= PTR_ZERO;
      head_q   <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      pend_q   <= CNT_ZERO;
      drop_q   <= CNT_ZERO;
    end else begin
      fpc_q    <= fpc_d;
      filled_q <= filled_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
    end
  end

  // Buffer payload; it is only ever read behind a set filled flag, so it needs no reset.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    word_q <= word_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (RESET_PC=0, DEPTH=2). The in-bench memory
// returns word = addr ^ 32'hA5A5_0000 after a programmable latency. Expected
// PCs are queued when a test sets them up and are popped on every decode
// handshake.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q   [$];
  logic [31:0] exp_q   [$];
  logic [31:0] req_log [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int pops = 0;
  int first_pop_cyc = -1;
  int t0 = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive this cycle's memory response, then let the DUT settle.
  task automatic settle();
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].addr ^ 32'hA5A5_0000;
      mem_q.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0000_0000;
    end
    #1;
  endtask

  // Record accepted requests and handshakes, then move to the next cycle.
  task automatic advance();
    logic [31:0] e;
    if (rst) begin
      mem_q.delete();
    end else if (imem_req && imem_gnt) begin
      mem_q.push_back('{addr: imem_addr, due: cyc + lat});
      req_log.push_back(imem_addr);
    end
    if (!rst && !redirect && inst_valid && inst_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_inst observed_pc=%h expected=none", inst_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e);
        chk("inst_word", inst, e ^ 32'hA5A5_0000);
      end
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      pops++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    req_log.delete();
  endtask

  task automatic wait_deliver(input int n, input int budget, input string tag);
    int start;
    start = pops;
    for (int i = 0; i < budget && (pops - start) < n; i++) tick();
    checks++;
    assert ((pops - start) >= n) else begin
      errors++;
      $error("FAIL %s_timeout observed=%0d expected=%0d", tag, pops - start, n);
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b1;
    inst_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);

    // 1) reset, then stream with 1-cycle memory
    lat = 1;
    settle();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    advance();
    rst = 1'b0;
    exp_q.delete(); req_log.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    t0 = cyc;
    settle();
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0000_0000);
    chk("post_rst_valid", 32'(inst_valid), 32'd0);
    advance();
    wait_deliver(4, 40, "stream");
    chk("first_latency", 32'(first_pop_cyc - t0), 32'd2);

    // 2) backpressure
    inst_ready = 1'b0; imem_gnt = 1'b1; lat = 1;
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int i = 0; i < 6; i++) tick();
    chk("bp_req_count", 32'(req_log.size()), 32'd2);
    chk("bp_req0", req_log[0], 32'h0);
    chk("bp_req1", req_log[1], 32'h4);
    settle();
    chk("bp_req_low", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    advance();
    settle();
    chk("bp_rereq", 32'(imem_req), 32'd1);
    chk("bp_rereq_addr", imem_addr, 32'h8);
    advance();
    wait_deliver(1, 20, "bp_tail");

    // 3) redirect with two requests in flight, 3-cycle memory
    inst_ready = 1'b1; imem_gnt = 1'b1; lat = 3;
    do_reset();
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    settle();
    chk("rd_req_in_redirect", 32'(imem_req), 32'd0);
    advance();
    redirect = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    settle();
    chk("rd_req_held_by_drop", 32'(imem_req), 32'd0);
    advance();
    wait_deliver(2, 40, "rd_inflight");
    chk("rd_req_before", 32'(req_log.size() >= 3), 32'd1);
    chk("rd_first_target", req_log[2], 32'h100);

    // 4) redirect in the same cycle as a response, 2-cycle memory
    inst_ready = 1'b0; imem_gnt = 1'b1; lat = 2;
    do_reset();
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    settle();
    chk("co_req", 32'(imem_req), 32'd1);
    chk("co_addr", imem_addr, 32'h200);
    advance();
    inst_ready = 1'b1;
    wait_deliver(2, 30, "co_rvalid");

    // 5) grant stall and 32-bit PC wrap
    inst_ready = 1'b1; imem_gnt = 1'b0; lat = 1;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, 32'hFFFF_FFF8);
      advance();
    end
    imem_gnt = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    wait_deliver(3, 40, "wrap");
    chk("wrap_req1", req_log[1], 32'hFFFF_FFFC);
    chk("wrap_req2", req_log[2], 32'h0000_0000);

    // 6) reset while the buffer is full
    inst_ready = 1'b0; imem_gnt = 1'b1; lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    settle();
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_req", 32'(imem_req), 32'd0);
    advance();
    rst = 1'b1;
    settle();
    chk("mid_rst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    advance();
    rst = 1'b0;
    exp_q.delete(); req_log.delete();
    settle();
    chk("after_rst_valid", 32'(inst_valid), 32'd0);
    chk("after_rst_req", 32'(imem_req), 32'd1);
    chk("after_rst_addr", imem_addr, 32'h0000_0000);
    advance();
    inst_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    wait_deliver(3, 40, "restart");
    chk("restart_leftover", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
